// File: rtl/line_buffer_bank.sv
// line_buffer_bank
//   Multi-row line buffer for streaming raster pixels. Keeps the previous
//   NUM_ROWS lines in NUM_ROWS row memories used circularly. For every
//   accepted pixel it emits a vertically aligned column of NUM_ROWS+1 taps
//   one cycle later.
//
//   Optional feature macro: LINEBUF_LEN_CHECK_EN
//     adds in_eol (line-end marker) and sticky len_err (line length error).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     pixel accepted this cycle (always ready)
//   in_sof       qualifies in_valid: first pixel of a new frame
//   in_data      pixel value
//   in_eol       (LINEBUF_LEN_CHECK_EN) qualifies in_valid: last pixel of line
//   len_err      (LINEBUF_LEN_CHECK_EN) sticky line-length error
//   out_valid    taps valid
//   out_taps     tap k at [k*DATA_W +: DATA_W]; tap 0 = current pixel,
//                tap k = same column k lines earlier
//   out_col      column of the output pixel
//   out_eol      output pixel is the last column
//   out_rows_ok  all older taps hold data of the current frame
module line_buffer_bank #(
  parameter int DATA_W    = 8,
  parameter int LINE_W    = 640,
  parameter int NUM_ROWS  = 2,
  parameter int ADDR_BITS = $clog2(LINE_W)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic [DATA_W-1:0]              in_data,
`ifdef LINEBUF_LEN_CHECK_EN
  input  logic                           in_eol,
  output logic                           len_err,
`endif
  output logic                           out_valid,
  output logic [(NUM_ROWS+1)*DATA_W-1:0] out_taps,
  output logic [ADDR_BITS-1:0]           out_col,
  output logic                           out_eol,
  output logic                           out_rows_ok
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int LW = $clog2(NUM_ROWS + 1);

  localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(LINE_W - 1);
  localparam logic [RW-1:0]        LAST_ROW = RW'(NUM_ROWS - 1);
  localparam logic [LW-1:0]        FULL     = LW'(NUM_ROWS);

  typedef enum logic [1:0] {IDLE, FILL, STEADY} state_t;

  state_t state, state_n;

  logic [ADDR_BITS-1:0] col;
  logic [RW-1:0]        wr_row;
  logic [LW-1:0]        lines_seen;

  logic                 acc;
  logic                 accept_ok;
  logic [ADDR_BITS-1:0] eff_col, col_n;
  logic [RW-1:0]        eff_row, row_n;
  logic [LW-1:0]        eff_lines, lines_n;
  logic                 wrap;

  logic [DATA_W-1:0]    mem [NUM_ROWS][LINE_W];
  logic [DATA_W-1:0]    rd_q [NUM_ROWS];
  logic [DATA_W-1:0]    tap0_q;
  logic [RW-1:0]        wr_row_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state;
    if (in_valid && in_sof)
      state_n = FILL;
    else if (state == FILL && acc && wrap && lines_n == FULL)
      state_n = STEADY;
  end

  // ---------------- FSM: outputs ----------------
  // Outside IDLE every pixel is taken; in IDLE only a frame start is.
  always_comb begin
    accept_ok = (state != IDLE) || in_sof;
    acc       = in_valid && accept_ok;
  end

  // ---------------- counter next values ----------------
  // A frame start overrides the live counters for its own pixel, so the
  // wrap test below already sees column 0 and sof wins over the wrap.
  always_comb begin
    eff_col   = in_sof ? '0 : col;
    eff_row   = in_sof ? '0 : wr_row;
    eff_lines = in_sof ? '0 : lines_seen;
    wrap      = (eff_col == LAST_COL);
    col_n     = eff_col + ADDR_BITS'(1);
    row_n     = eff_row;
    lines_n   = eff_lines;
    if (wrap) begin
      col_n   = '0;
      row_n   = (eff_row == LAST_ROW) ? '0 : eff_row + RW'(1);
      lines_n = (eff_lines < FULL) ? eff_lines + LW'(1) : eff_lines;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      wr_row     <= '0;
      lines_seen <= '0;
    end else if (acc) begin
      col        <= col_n;
      wr_row     <= row_n;
      lines_seen <= lines_n;
    end
  end

  // ---------------- row memories (not reset) ----------------
  always_ff @(posedge clk) begin
    if (acc) mem[eff_row][eff_col] <= in_data;
  end

  // Read-before-write: each slot returns its pre-write contents.
  for (genvar s = 0; s < NUM_ROWS; s++) begin : g_rd
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   rd_q[s] <= '0;
      else if (acc) rd_q[s] <= mem[s][eff_col];
    end
  end

  // ---------------- registered pixel side info ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      tap0_q      <= '0;
      wr_row_q    <= '0;
      out_col     <= '0;
      out_eol     <= 1'b0;
      out_rows_ok <= 1'b0;
    end else begin
      out_valid <= acc;
      if (acc) begin
        tap0_q      <= in_data;
        wr_row_q    <= eff_row;
        out_col     <= eff_col;
        out_eol     <= wrap;
        out_rows_ok <= (eff_lines == FULL);
      end
    end
  end

  // ---------------- tap mux ----------------
  // Slot for tap k is (wr_row_q - k) mod NUM_ROWS, using the pointer that
  // was registered together with the read data.
  assign out_taps[DATA_W-1:0] = tap0_q;

  for (genvar k = 1; k <= NUM_ROWS; k++) begin : g_tap
    localparam logic [RW:0] KV = (RW+1)'(k);
    localparam logic [RW:0] NV = (RW+1)'(NUM_ROWS);
    logic [RW:0] sel;
    assign sel = ({1'b0, wr_row_q} >= KV) ? ({1'b0, wr_row_q} - KV)
                                          : ({1'b0, wr_row_q} + NV - KV);
    assign out_taps[k*DATA_W +: DATA_W] = rd_q[sel[RW-1:0]];
  end

`ifdef LINEBUF_LEN_CHECK_EN
  // Error when the marker and the counter disagree about the line end.
  // A frame start clears the flag before its own pixel is checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   len_err <= 1'b0;
    else if (acc) len_err <= (in_sof ? 1'b0 : len_err) | (in_eol != wrap);
  end
`endif

endmodule

// File: tb/tb_line_buffer_bank.sv
module tb_line_buffer_bank;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int NR = 2;
  localparam int AB = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sof = 1'b0;
  logic                 in_eol = 1'b0;
  logic [DW-1:0]        in_data = '0;
  logic                 out_valid;
  logic [(NR+1)*DW-1:0] out_taps;
  logic [AB-1:0]        out_col;
  logic                 out_eol;
  logic                 out_rows_ok;
`ifdef LINEBUF_LEN_CHECK_EN
  logic                 len_err;
`endif

  int errors = 0;
  int checks = 0;

  line_buffer_bank #(.DATA_W(DW), .LINE_W(LW), .NUM_ROWS(NR), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
`ifdef LINEBUF_LEN_CHECK_EN
    .in_eol(in_eol), .len_err(len_err),
`endif
    .out_valid(out_valid), .out_taps(out_taps), .out_col(out_col),
    .out_eol(out_eol), .out_rows_ok(out_rows_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input; returns 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic sof, input logic [DW-1:0] d, input logic eol);
    @(negedge clk);
    in_valid = v; in_sof = sof; in_data = d; in_eol = eol;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  // Accepted pixel j of the current frame with value v; older taps are
  // v-4 and v-8 because every stream below increments by one per pixel.
  task automatic px(input int j, input logic [DW-1:0] v, input logic sof);
    int ln, c;
    ln = j / LW;
    c  = j % LW;
    step(1'b1, sof, v, c == LW-1);
    chk($sformatf("valid_j%0d", j), 32'(out_valid), 32'd1);
    chk($sformatf("col_j%0d", j), 32'(out_col), 32'(c));
    chk($sformatf("eol_j%0d", j), 32'(out_eol), 32'(c == LW-1));
    chk($sformatf("rows_ok_j%0d", j), 32'(out_rows_ok), 32'(ln >= 2));
    chk($sformatf("tap0_j%0d", j), 32'(out_taps[7:0]), 32'(v));
    if (ln >= 1) chk($sformatf("tap1_j%0d", j), 32'(out_taps[15:8]), 32'(v - 8'd4));
    if (ln >= 2) chk($sformatf("tap2_j%0d", j), 32'(out_taps[23:16]), 32'(v - 8'd8));
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_taps", 32'(out_taps), 32'd0);
    chk("rst_col", 32'(out_col), 32'd0);
    chk("rst_eol", 32'(out_eol), 32'd0);
    chk("rst_rows_ok", 32'(out_rows_ok), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // pixels without sof are dropped in IDLE
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
      chk($sformatf("idle_valid_%0d", i), 32'(out_valid), 32'd0);
    end
    chk("idle_taps", 32'(out_taps), 32'd0);

    // frame 0..11, contiguous
    for (int j = 0; j < 12; j++) begin
      px(j, 8'(j), j == 0);
      if (j == 9) chk("taps_l2c1", 32'(out_taps), 32'h010509);
    end

    // same stream with gaps; outputs hold while in_valid is low
    for (int j = 0; j < 12; j++) begin
      px(j, 8'(j), j == 0);
      step(1'b0, 1'b0, 8'hEE, 1'b0);
      chk($sformatf("gap_valid_%0d", j), 32'(out_valid), 32'd0);
      chk($sformatf("gap_tap0_%0d", j), 32'(out_taps[7:0]), 32'(j));
      chk($sformatf("gap_col_%0d", j), 32'(out_col), 32'(j % LW));
    end

    // mid-line sof at pixel 6 restarts the counters on that pixel
    for (int j = 0; j < 6; j++) px(j, 8'(j), j == 0);
    for (int j = 0; j < 12; j++) px(j, 8'(6 + j), j == 0);

    // reset mid-line
    for (int j = 0; j < 5; j++) px(j, 8'(8'h40 + j), j == 0);
    @(negedge clk) rst_n = 1'b0;
    #2;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_taps", 32'(out_taps), 32'd0);
    chk("mrst_col", 32'(out_col), 32'd0);
    chk("mrst_eol", 32'(out_eol), 32'd0);
    chk("mrst_rows_ok", 32'(out_rows_ok), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h55, 1'b0);
    chk("post_rst_nosof", 32'(out_valid), 32'd0);
    px(0, 8'h60, 1'b1);
    px(1, 8'h61, 1'b0);

`ifdef LINEBUF_LEN_CHECK_EN
    px(0, 8'h70, 1'b1);
    chk("len_err_clean", 32'(len_err), 32'd0);
    step(1'b1, 1'b0, 8'h71, 1'b0);
    chk("len_err_c1", 32'(len_err), 32'd0);
    step(1'b1, 1'b0, 8'h72, 1'b1);
    chk("len_err_set", 32'(len_err), 32'd1);
    step(1'b1, 1'b0, 8'h73, 1'b1);
    chk("len_err_hold1", 32'(len_err), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("len_err_hold2", 32'(len_err), 32'd1);
    px(0, 8'h80, 1'b1);
    chk("len_err_clr", 32'(len_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/line_buffer_bank.md
# line_buffer_bank

Multi-row line buffer for streaming raster pixels. It holds the previous NUM_ROWS lines in NUM_ROWS single-port-style row memories (write and read at the same column each cycle) and rotates them circularly. For every accepted pixel it presents a vertically aligned column of NUM_ROWS+1 taps. It sits between the pixel ingest stage and the window/kernel stages (3x3, 5x5) of the edge pipeline.

## Interface
- DATA_W, 8: pixel width in bits
- LINE_W, 640: pixels per line
- NUM_ROWS, 2: stored previous lines (window height minus 1), 1..8
- ADDR_BITS, $clog2(LINE_W): column address width
- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel accepted this cycle (no backpressure; block always ready)
- in_sof  in  1  qualifies in_valid; pixel is column 0 of line 0 of a new frame
- in_data  in  DATA_W  pixel
- out_valid  out  1  taps valid
- out_taps  out  (NUM_ROWS+1)*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; tap 0 = current pixel, tap k = same column k lines earlier
- out_col  out  ADDR_BITS  column of the output pixel
- out_eol  out  1  output pixel is column LINE_W-1
- out_rows_ok  out  1  all NUM_ROWS older taps hold real data of the current frame

## Operation
- State machine: IDLE -> FILL on in_valid&in_sof; FILL -> STEADY when the line counter reaches NUM_ROWS (at the end of line NUM_ROWS-1); in_valid&in_sof in FILL or STEADY restarts the frame (re-enters FILL, or STEADY if NUM_ROWS is 0, which is not allowed).
- In IDLE, in_valid without in_sof is dropped: no write, no out_valid.
- Counters: col (0..LINE_W-1) and wr_row slot pointer (0..NUM_ROWS-1). lines_seen saturates at NUM_ROWS.
- On an accepted pixel at column c: every slot is read at address c (read-before-write: the old contents are returned), and in_data is written to slot wr_row at address c.
- Tap mapping: tap k (1..NUM_ROWS) comes from slot (wr_row_at_read - k) mod NUM_ROWS. For k = NUM_ROWS this is slot wr_row, returning its pre-write contents. The mux uses the wr_row registered alongside the read, not the live pointer.
- At c = LINE_W-1: col wraps to 0, wr_row advances modulo NUM_ROWS, and lines_seen increments if it is below NUM_ROWS.
- in_sof: col is forced to 0 for that pixel, wr_row to 0, and lines_seen to 0. The pixel is written normally. Old memory contents persist, but out_rows_ok masks them.
- out_rows_ok = (lines_seen sampled with the pixel) == NUM_ROWS.
- Memories are not reset. Their contents are undefined until written.

## Timing
- Latency 1 cycle: out_valid, out_taps, out_col, out_eol, and out_rows_ok are registered and appear the cycle after the accepted in_valid. Tap 0 is in_data delayed by 1.
- Throughput: 1 pixel per cycle, with gaps (in_valid low) allowed anywhere. Outputs other than out_valid hold their last values during gaps.
- Reset: out_valid=0, out_taps=0, out_col=0, out_eol=0, out_rows_ok=0, state IDLE, col=0, wr_row=0, lines_seen=0. Reset asserted mid-line discards the line; the next frame needs in_sof.
- Simultaneous sof with the wrap column: sof wins (col=0, wr_row=0).
- Mid-line sof: the partial line is abandoned and counters restart on that pixel.

## Configuration
- LINEBUF_LEN_CHECK_EN defined:
  - Adds input in_eol (1 bit, qualifies in_valid) and output len_err (1 bit, sticky, reset 0).
  - len_err sets the cycle after either of these: in_eol arrives with col != LINE_W-1, or col == LINE_W-1 is accepted without in_eol.
  - len_err clears only on in_valid&in_sof or on reset.
  - Counter behaviour is unchanged; the counters stay LINE_W-based.
- Macro undefined: neither port exists and line length is implied by LINE_W only.

## Test plan
- Reset then pixels without sof (data 0x11..0x1F) -> out_valid stays 0, no writes.
- LINE_W=4, NUM_ROWS=2, frame 0..11 (value = index), sof on first pixel:
  - Line 2, col 1 gives taps {9,5,1}, out_rows_ok=1.
  - Lines 0 and 1 give out_rows_ok=0.
  - out_eol is high at cols 3, 7, 11.
- Same stream with in_valid toggling every other cycle -> identical tap sequence; outputs hold during gaps.
- Second sof at pixel 6 (mid line 1) -> that pixel has out_col=0 and out_rows_ok=0, and rows_ok returns 2 lines later.
- Reset asserted at pixel 5 then released -> all outputs 0 next cycle, IDLE until sof.
- With LINEBUF_LEN_CHECK_EN, LINE_W=4: in_eol at col 2 -> len_err=1 the next cycle, held until the next sof.
